// File: rtl/led_pwm_driver.sv
// led_pwm_driver
// Turns the LED PIO control word into glitch-free PWM brightness with
// optional blinking and an optional one-step-per-frame linear fade.
// Every visible field is sampled only at a PWM frame boundary, so a
// control write never truncates or stretches a frame that is in flight.
module led_pwm_driver #(
    parameter int NUM_LEDS    = 8,
    parameter int PRESCALE    = 50,
    parameter int BLINK_SCALE = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         ctrl_word,
    output logic [NUM_LEDS-1:0] leds,
    output logic                frame_pulse,
    output logic [7:0]          cur_duty,
    output logic                fading
);

    localparam int                PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [11:0]       BLINK_MUL = 12'(BLINK_SCALE);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd2;

    logic [20:0]         r_ctrl_q;
    logic [PRE_W-1:0]    r_pre_cnt;
    logic [7:0]          r_pwm_cnt;
    logic                r_frame_pulse;
    logic [NUM_LEDS-1:0] r_mask_sh;
    logic [3:0]          r_rate_sh;
    logic [11:0]         r_blink_cnt;
    logic                r_blink_phase;
    logic [7:0]          r_cur_duty;
    logic [1:0]          r_state;
    logic [NUM_LEDS-1:0] r_leds;

    logic                w_step;
    logic                w_boundary;
    logic                w_pwm_on;
    logic [NUM_LEDS-1:0] w_mask_in;
    logic [7:0]          w_tgt;
    logic [3:0]          w_rate_in;
    logic                w_fade_en;
    logic [11:0]         w_blink_last;
    logic [7:0]          w_duty_nxt;
    logic [1:0]          w_state_nxt;
    logic                w_unused_ctrl;

    // Bits [31:21] of the PIO word are reserved; they are deliberately dropped.
    assign w_unused_ctrl = ^ctrl_word[31:21];

    assign w_mask_in  = r_ctrl_q[NUM_LEDS-1:0];
    assign w_tgt      = r_ctrl_q[15:8];
    assign w_rate_in  = r_ctrl_q[19:16];
    assign w_fade_en  = r_ctrl_q[20];

    assign w_step     = (r_pre_cnt == PRE_LAST);
    assign w_boundary = w_step && (r_pwm_cnt == 8'hFF);
    assign w_pwm_on   = (r_pwm_cnt < r_cur_duty);

    // Blink period in frames minus one; only consulted when the rate is non-zero.
    assign w_blink_last = ({8'd0, r_rate_sh} * BLINK_MUL) - 12'd1;

    // Register the control word once; all later logic sees only this copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl_q <= '0;
        end else begin
            r_ctrl_q <= ctrl_word[20:0];
        end
    end

    // Prescaler: one PWM step every PRESCALE clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre_cnt <= '0;
        end else if (w_step) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PRE_W'(1);
        end
    end

    // PWM position counter plus the pulse marking the first cycle of a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt     <= '0;
            r_frame_pulse <= 1'b0;
        end else begin
            r_frame_pulse <= w_boundary;
            if (w_step) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end
        end
    end

    // Shadow mask/rate at the frame boundary and run the frame-based blink timer.
    // A new rate restarts the blink cycle in the ON phase so the change is visible at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask_sh     <= '0;
            r_rate_sh     <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_boundary) begin
            r_mask_sh <= w_mask_in;
            r_rate_sh <= w_rate_in;
            if ((w_rate_in != r_rate_sh) || (w_rate_in == 4'd0)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b1;
            end else if (r_blink_cnt == w_blink_last) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 12'd1;
            end
        end
    end

    // Fade decision for the next boundary. The ramp step is taken in the same
    // boundary that detects the mismatch, so IDLE and both ramp states share one
    // rule; the state only records the direction for the fading readback.
    // Stepping toward the target by one can never pass it, so no wrap is possible.
    always_comb begin
        w_duty_nxt  = r_cur_duty;
        w_state_nxt = r_state;
        if (!w_fade_en) begin
            w_duty_nxt  = w_tgt;
            w_state_nxt = ST_IDLE;
        end else if (w_tgt > r_cur_duty) begin
            w_duty_nxt  = r_cur_duty + 8'd1;
            w_state_nxt = ST_RAMP_UP;
        end else if (w_tgt < r_cur_duty) begin
            w_duty_nxt  = r_cur_duty - 8'd1;
            w_state_nxt = ST_RAMP_DOWN;
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Commit the fade decision only at frame boundaries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_duty <= '0;
            r_state    <= ST_IDLE;
        end else if (w_boundary) begin
            r_cur_duty <= w_duty_nxt;
            r_state    <= w_state_nxt;
        end
    end

    // Registered LED drive: mask, PWM compare and blink phase combined.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_leds <= '0;
        end else begin
            r_leds <= r_mask_sh & {NUM_LEDS{w_pwm_on & r_blink_phase}};
        end
    end

    assign leds        = r_leds;
    assign frame_pulse = r_frame_pulse;
    assign cur_duty    = r_cur_duty;
    assign fading      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver
// Directed stimulus issues one control word per PWM frame and queues the
// hand-computed expectation for the following frame; a monitor integrates
// each LED over every frame and checks it, the duty and the fade flag
// against the queued expectation when the next frame_pulse arrives.
`timescale 1ns/1ps
module tb_led_pwm_driver;

    localparam int NUM_LEDS    = 8;
    localparam int PRESCALE    = 4;
    localparam int BLINK_SCALE = 2;
    localparam int FRAME_CLK   = 256 * PRESCALE;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [31:0]         ctrl_word = 32'h0;
    logic [NUM_LEDS-1:0] leds;
    logic                frame_pulse;
    logic [7:0]          cur_duty;
    logic                fading;

    int n_checks = 0;
    int n_fail   = 0;
    int stim_frame = 0;

    typedef struct {
        int         frame;
        logic [7:0] duty;
        logic       fade;
        logic [7:0] lit;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    led_pwm_driver #(
        .NUM_LEDS    (NUM_LEDS),
        .PRESCALE    (PRESCALE),
        .BLINK_SCALE (BLINK_SCALE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ctrl_word   (ctrl_word),
        .leds        (leds),
        .frame_pulse (frame_pulse),
        .cur_duty    (cur_duty),
        .fading      (fading)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic wait_fp();
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!frame_pulse && budget < 2 * FRAME_CLK);
        if (!frame_pulse) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_pulse_timeout: no frame_pulse within %0d clk", budget);
        end
        stim_frame++;
    endtask

    task automatic expect_next(input logic [7:0] duty, input logic fade, input logic [7:0] lit);
        exp_t e;
        e.frame = stim_frame + 1;
        e.duty  = duty;
        e.fade  = fade;
        e.lit   = lit;
        exp_q.push_back(e);
    endtask

    task automatic frame_step(input logic [31:0] w, input logic [7:0] duty,
                              input logic fade, input logic [7:0] lit);
        ctrl_word = w;
        expect_next(duty, fade, lit);
        wait_fp();
    endtask

    // Monitor: integrate LED on-time per frame and score it at the next frame_pulse.
    initial begin : monitor
        int         cnt [NUM_LEDS];
        int         mon_frame;
        logic [7:0] duty_s;
        logic       fade_s;
        exp_t       e;
        mon_frame = 0;
        duty_s = '0;
        fade_s = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_frame = 0;
                for (int i = 0; i < NUM_LEDS; i++) cnt[i] = 0;
            end else begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (leds[i]) cnt[i]++;
                end
                if (frame_pulse) begin
                    while (exp_q.size() > 0 && exp_q[0].frame < mon_frame) begin
                        e = exp_q.pop_front();
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame%0d_missed: expectation never scored", e.frame);
                    end
                    if (exp_q.size() > 0 && exp_q[0].frame == mon_frame) begin
                        e = exp_q.pop_front();
                        check($sformatf("frame%0d_cur_duty", mon_frame), int'(duty_s), int'(e.duty));
                        check($sformatf("frame%0d_fading", mon_frame), int'(fade_s), int'(e.fade));
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            check($sformatf("frame%0d_led%0d_on_cycles", mon_frame, i), cnt[i],
                                  e.lit[i] ? int'(e.duty) * PRESCALE : 0);
                        end
                    end
                    mon_frame++;
                    duty_s = cur_duty;
                    fade_s = fading;
                    for (int i = 0; i < NUM_LEDS; i++) cnt[i] = 0;
                end
            end
        end
    end

    // Stimulus.
    initial begin : stim
        int edges;
        reset_n   = 1'b0;
        ctrl_word = 32'h0;
        repeat (3) @(negedge clk);

        // Reset held: control word activity must not reach the outputs.
        for (int i = 0; i < 6; i++) begin
            ctrl_word = 32'h001F_FFFF ^ (i * 32'h0001_1111);
            @(negedge clk);
        end
        check("reset_leds", int'(leds), 0);
        check("reset_cur_duty", int'(cur_duty), 0);
        check("reset_fading", int'(fading), 0);
        check("reset_frame_pulse", int'(frame_pulse), 0);

        // 50% duty on LED0 only.
        ctrl_word = 32'h0000_8001;
        expect_next(8'h80, 1'b0, 8'h01);
        reset_n = 1'b1;
        edges = 0;
        while (!frame_pulse && edges < 2 * FRAME_CLK) begin
            @(negedge clk);
            edges++;
        end
        check("first_frame_pulse_latency", edges, FRAME_CLK);
        stim_frame = 1;
        frame_step(32'h0000_8001, 8'h80, 1'b0, 8'h01);

        // Full duty on all LEDs, then duty 0 with all masked in.
        frame_step(32'h0000_FFFF, 8'hFF, 1'b0, 8'hFF);
        frame_step(32'h0000_00FF, 8'h00, 1'b0, 8'hFF);

        // Blink rate 1: two frames on, two dark; then rate 0 returns to steady.
        frame_step(32'h0001_FF01, 8'hFF, 1'b0, 8'h01);
        frame_step(32'h0001_FF01, 8'hFF, 1'b0, 8'h01);
        frame_step(32'h0001_FF01, 8'hFF, 1'b0, 8'h00);
        frame_step(32'h0001_FF01, 8'hFF, 1'b0, 8'h00);
        frame_step(32'h0001_FF01, 8'hFF, 1'b0, 8'h01);
        frame_step(32'h0001_FF01, 8'hFF, 1'b0, 8'h01);
        frame_step(32'h0000_FF01, 8'hFF, 1'b0, 8'h01);

        // Fade up from 0 to 0x10, then down to 0x08.
        frame_step(32'h0000_0001, 8'h00, 1'b0, 8'h01);
        for (int j = 1; j <= 16; j++) begin
            frame_step(32'h0010_1001, 8'(j), 1'b1, 8'h01);
        end
        frame_step(32'h0010_1001, 8'h10, 1'b0, 8'h01);
        for (int j = 15; j >= 8; j--) begin
            frame_step(32'h0010_0801, 8'(j), 1'b1, 8'h01);
        end
        frame_step(32'h0010_0801, 8'h08, 1'b0, 8'h01);

        // Ramp toward 0x40, abandon the fade mid-ramp: jump to target.
        frame_step(32'h0010_4001, 8'h09, 1'b1, 8'h01);
        frame_step(32'h0010_4001, 8'h0A, 1'b1, 8'h01);
        frame_step(32'h0010_4001, 8'h0B, 1'b1, 8'h01);
        frame_step(32'h0000_4001, 8'h40, 1'b0, 8'h01);

        // Ramp toward 0x80, then async reset between clock edges mid-ramp.
        frame_step(32'h0010_8001, 8'h41, 1'b1, 8'h01);
        wait_fp();
        repeat (20) @(negedge clk);
        check("preinterrupt_cur_duty", int'(cur_duty), 8'h42);
        check("preinterrupt_fading", int'(fading), 1);
        check("preinterrupt_led0", int'(leds[0]), 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_leds", int'(leds), 0);
        check("async_reset_cur_duty", int'(cur_duty), 0);
        check("async_reset_fading", int'(fading), 0);
        check("async_reset_frame_pulse", int'(frame_pulse), 0);
        repeat (3) @(negedge clk);

        // Ramp restarts from duty 0.
        stim_frame = 0;
        expect_next(8'h01, 1'b1, 8'h01);
        reset_n = 1'b1;
        wait_fp();
        expect_next(8'h02, 1'b1, 8'h01);
        wait_fp();
        expect_next(8'h03, 1'b1, 8'h01);
        wait_fp();
        wait_fp();
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
